// File: rtl/demux_1_2_buf.sv
// Buffered 1:2 steering demux with an independent FIFO per destination.
// Optional per-destination delivery counters are enabled by defining DEMUX_COUNT_EN.
module demux_1_2_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_in,
    input  logic             sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out1,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out2,
    output logic             out2_valid,
    input  logic             out2_ready
`ifdef DEMUX_COUNT_EN
    ,
    output logic [15:0]      cnt1,
    output logic [15:0]      cnt2
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    // Index 0 is the out1 FIFO, index 1 is the out2 FIFO.
    logic [WIDTH-1:0] mem_r    [2][DEPTH];
    logic [AW-1:0]    wr_ptr_r [2];
    logic [AW-1:0]    rd_ptr_r [2];
    logic [AW:0]      count_r  [2];

    logic [1:0]       full_s;
    logic [1:0]       empty_s;
    logic [1:0]       push_s;
    logic [1:0]       pop_s;

    // Handshake decode; in_ready depends only on sel and registered fullness.
    always_comb begin
        full_s[0]  = (count_r[0] == CNT_FULL);
        full_s[1]  = (count_r[1] == CNT_FULL);
        empty_s[0] = (count_r[0] == '0);
        empty_s[1] = (count_r[1] == '0);
        if (sel) begin
            in_ready = ~full_s[1];
        end else begin
            in_ready = ~full_s[0];
        end
        push_s[0] = in_valid & ~sel & ~full_s[0];
        push_s[1] = in_valid &  sel & ~full_s[1];
        pop_s[0]  = ~empty_s[0] & out1_ready;
        pop_s[1]  = ~empty_s[1] & out2_ready;
    end

    // FIFO storage, pointers and occupancy; reset wins over any push or pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int f = 0; f < 2; f++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem_r[f][i] <= '0;
                end
                wr_ptr_r[f] <= '0;
                rd_ptr_r[f] <= '0;
                count_r[f]  <= '0;
            end
        end else begin
            for (int f = 0; f < 2; f++) begin
                if (push_s[f]) begin
                    mem_r[f][wr_ptr_r[f]] <= d_in;
                    wr_ptr_r[f]           <= wr_ptr_r[f] + PTR_ONE;
                end
                if (pop_s[f]) begin
                    rd_ptr_r[f] <= rd_ptr_r[f] + PTR_ONE;
                end
                case ({push_s[f], pop_s[f]})
                    2'b10:   count_r[f] <= count_r[f] + CNT_ONE;
                    2'b01:   count_r[f] <= count_r[f] - CNT_ONE;
                    default: count_r[f] <= count_r[f];
                endcase
            end
        end
    end

    // Head words come straight from registered storage, no fall-through path.
    always_comb begin
        out1       = mem_r[0][rd_ptr_r[0]];
        out2       = mem_r[1][rd_ptr_r[1]];
        out1_valid = ~empty_s[0];
        out2_valid = ~empty_s[1];
    end

`ifdef DEMUX_COUNT_EN
    // Delivery counters, wrapping naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt1 <= 16'd0;
            cnt2 <= 16'd0;
        end else begin
            if (pop_s[0]) begin
                cnt1 <= cnt1 + 16'd1;
            end
            if (pop_s[1]) begin
                cnt2 <= cnt2 + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_demux_1_2_buf.sv
// Directed self-checking bench for demux_1_2_buf (DEPTH=2).
module tb_demux_1_2_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] d_in;
    logic        sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out1;
    logic        out1_valid;
    logic        out1_ready;
    logic [31:0] out2;
    logic        out2_valid;
    logic        out2_ready;
`ifdef DEMUX_COUNT_EN
    logic [15:0] cnt1;
    logic [15:0] cnt2;
`endif

    int checks = 0;
    int errors = 0;

    demux_1_2_buf #(.WIDTH(32), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .d_in(d_in), .sel(sel), .in_valid(in_valid),
        .in_ready(in_ready),
        .out1(out1), .out1_valid(out1_valid), .out1_ready(out1_ready),
        .out2(out2), .out2_valid(out2_valid), .out2_ready(out2_ready)
`ifdef DEMUX_COUNT_EN
        , .cnt1(cnt1), .cnt2(cnt2)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin : stim
        logic [31:0] q[$];
        int          model_cnt;
        int          sent;
        int          recv;
        int          cyc;
        logic        push;
        logic        pop;

        rst = 1'b1; d_in = 32'h0; sel = 1'b0; in_valid = 1'b0;
        out1_ready = 1'b0; out2_ready = 1'b0;

        // 1 reset
        tick; tick;
        chk("rst_out1_valid", {31'd0, out1_valid}, 32'd0);
        chk("rst_out2_valid", {31'd0, out2_valid}, 32'd0);
        chk("rst_out1", out1, 32'd0);
        chk("rst_out2", out2, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef DEMUX_COUNT_EN
        chk("rst_cnt1", {16'd0, cnt1}, 32'd0);
        chk("rst_cnt2", {16'd0, cnt2}, 32'd0);
`endif
        rst = 1'b0;

        // 2 steer
        out1_ready = 1'b1; out2_ready = 1'b1;
        d_in = 32'hA5A5_0001; sel = 1'b0; in_valid = 1'b1;
        tick;
        chk("steer_out1_valid", {31'd0, out1_valid}, 32'd1);
        chk("steer_out1", out1, 32'hA5A5_0001);
        chk("steer_out2_quiet", {31'd0, out2_valid}, 32'd0);
        d_in = 32'h0000_BEEF; sel = 1'b1;
        tick;
        chk("steer_out1_drained", {31'd0, out1_valid}, 32'd0);
        chk("steer_out2_valid", {31'd0, out2_valid}, 32'd1);
        chk("steer_out2", out2, 32'h0000_BEEF);
        in_valid = 1'b0;
        tick;
        chk("steer_out2_drained", {31'd0, out2_valid}, 32'd0);

        // 3 full and isolation
        out1_ready = 1'b0; out2_ready = 1'b0;
        sel = 1'b0; in_valid = 1'b1; d_in = 32'h0000_0011;
        tick;
        d_in = 32'h0000_0022;
        tick;
        chk("full_in_ready0", {31'd0, in_ready}, 32'd0);
        d_in = 32'h0000_0033;
        tick;
        chk("full_head_hold", out1, 32'h0000_0011);
        chk("full_still_ready0", {31'd0, in_ready}, 32'd0);
        sel = 1'b1; d_in = 32'h0000_0044;
        #1;
        chk("iso_in_ready_sel1", {31'd0, in_ready}, 32'd1);
        tick;
        in_valid = 1'b0;
        chk("iso_out2_valid", {31'd0, out2_valid}, 32'd1);
        chk("iso_out2", out2, 32'h0000_0044);
        out2_ready = 1'b1;
        tick;
        chk("iso_out2_drained", {31'd0, out2_valid}, 32'd0);
        out2_ready = 1'b0;

        // 4 full with same-cycle pop: push refused, accepted next cycle
        out1_ready = 1'b1; in_valid = 1'b1; sel = 1'b0; d_in = 32'h0000_0033;
        #1;
        chk("fullpop_in_ready0", {31'd0, in_ready}, 32'd0);
        tick;
        chk("fullpop_head", out1, 32'h0000_0022);
        chk("fullpop_in_ready1", {31'd0, in_ready}, 32'd1);
        out1_ready = 1'b0;
        tick;
        in_valid = 1'b0;
        chk("fullpop_full_again", {31'd0, in_ready}, 32'd0);
        out1_ready = 1'b1;
        tick;
        chk("fullpop_next", out1, 32'h0000_0033);
        tick;
        chk("fullpop_empty", {31'd0, out1_valid}, 32'd0);
`ifdef DEMUX_COUNT_EN
        chk("cnt1_after4", {16'd0, cnt1}, 32'd4);
        chk("cnt2_after4", {16'd0, cnt2}, 32'd2);
`endif

        // 5 wrap and order with toggling out1_ready
        model_cnt = 0; sent = 0; recv = 0; cyc = 0;
        sel = 1'b0;
        while ((sent < 10 || model_cnt != 0) && cyc < 60) begin
            in_valid   = (sent < 10);
            d_in       = 32'hC000_0000 + 32'(sent);
            out1_ready = cyc[0];
            #1;
            chk("wrap_in_ready", {31'd0, in_ready}, {31'd0, (model_cnt != 2)});
            chk("wrap_valid", {31'd0, out1_valid}, {31'd0, (model_cnt != 0)});
            if (model_cnt != 0) chk("wrap_data", out1, q[0]);
            push = in_valid && (model_cnt != 2);
            pop  = (model_cnt != 0) && out1_ready;
            tick;
            if (pop) begin
                void'(q.pop_front());
                recv++;
                model_cnt--;
            end
            if (push) begin
                q.push_back(d_in);
                sent++;
                model_cnt++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        chk("wrap_recv_count", 32'(recv), 32'd10);
        chk("wrap_no_timeout", {31'd0, (cyc < 60)}, 32'd1);
`ifdef DEMUX_COUNT_EN
        chk("cnt1_after5", {16'd0, cnt1}, 32'd14);
`endif

        // 6 mid-operation reset drops FIFO2 contents and any in-flight word
        out1_ready = 1'b0; out2_ready = 1'b0;
        sel = 1'b1; in_valid = 1'b1; d_in = 32'h0000_0055;
        tick;
        d_in = 32'h0000_0066;
        tick;
        chk("mid_out2_valid", {31'd0, out2_valid}, 32'd1);
        chk("mid_out2", out2, 32'h0000_0055);
        chk("mid_full_sel1", {31'd0, in_ready}, 32'd0);
        rst = 1'b1; d_in = 32'h0000_0077;
        tick;
        chk("mid_rst_out2_valid", {31'd0, out2_valid}, 32'd0);
        chk("mid_rst_out2", out2, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef DEMUX_COUNT_EN
        chk("mid_rst_cnt2", {16'd0, cnt2}, 32'd0);
        chk("mid_rst_cnt1", {16'd0, cnt1}, 32'd0);
`endif
        rst = 1'b0; in_valid = 1'b0; out2_ready = 1'b1;
        tick;
        chk("mid_words_gone", {31'd0, out2_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
